// File: rtl/fifo_reader_pkg.sv
// Shared types and sizing for the FIFO stream reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_e;

    localparam int BUF_DEPTH  = 2;
    localparam int STAT_WIDTH = 16;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Bundles the control, FIFO read side and downstream stream of the reader (stat_words under FIFO_READER_STATS_EN).
// Latency: n/a (wiring only).
// Backpressure: m_ready from the sink; fifo_empty from the source FIFO.
interface fifo_stream_reader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
);
    import fifo_reader_pkg::*;

    logic                  start;
    logic [LEN_WIDTH-1:0]  burst_len;
    logic                  busy;
    logic                  done;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_empty;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
`ifdef FIFO_READER_STATS_EN
    logic [STAT_WIDTH-1:0] stat_words;
`endif

    modport master (
        input  start, burst_len, fifo_dout, fifo_empty, m_ready,
`ifdef FIFO_READER_STATS_EN
        output stat_words,
`endif
        output busy, done, fifo_rd_en, m_valid, m_data
    );

    modport slave (
        output start, burst_len, fifo_dout, fifo_empty, m_ready,
`ifdef FIFO_READER_STATS_EN
        input  stat_words,
`endif
        input  busy, done, fifo_rd_en, m_valid, m_data
    );

endinterface

// File: rtl/fifo_reader_buf.sv
// Two-entry output skid buffer between FIFO read data and the downstream stream.
// Latency: a write is visible at head one cycle later; pop frees an entry at the same edge.
// Backpressure: a write while full is dropped unless a pop happens in the same cycle.
module fifo_reader_buf
    import fifo_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [1:0]            count
);

    localparam logic [1:0] FULL = 2'(BUF_DEPTH);

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic                  do_wr;
    logic                  do_pop;

    assign do_pop = pop && (count != 2'd0);
    assign do_wr  = wr_en && ((count != FULL) || do_pop);
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_wr, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// Reads burst_len words from a FIFO and streams them out on valid/ready; FIFO_READER_STATS_EN adds stat_words.
// Latency: first m_valid two cycles after the first fifo_rd_en, then 1 word/cycle.
// Backpressure: reads are throttled so at most two words are ever buffered or in flight.
module fifo_stream_reader
    import fifo_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_stream_reader_if.master bus
);

    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [2:0]           OCC_MAX  = 3'(BUF_DEPTH - 1);

    rd_state_e             state;
    logic [LEN_WIDTH-1:0]  issue_left;
    logic [LEN_WIDTH-1:0]  deliver_left;
    logic                  pending;
    logic [1:0]            buf_count;
    logic                  busy_r;
    logic                  done_r;
    logic                  hs;
    logic                  rd_en;
    logic [2:0]            occ_next;

    assign hs = bus.m_valid && bus.m_ready;

    // Occupancy after this edge; a new read lands one edge later, so it must leave room.
    assign occ_next = {1'b0, buf_count} + {2'b00, pending} - {2'b00, hs};
    assign rd_en    = (state == RUN) && !bus.fifo_empty && (issue_left != '0) && (occ_next <= OCC_MAX);

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = (buf_count != 2'd0);
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;

    fifo_reader_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (pending),
        .wr_data (bus.fifo_dout),
        .pop     (hs),
        .head    (bus.m_data),
        .count   (buf_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            issue_left   <= '0;
            deliver_left <= '0;
            pending      <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            pending <= rd_en;
            done_r  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        issue_left   <= bus.burst_len;
                        deliver_left <= bus.burst_len;
                        if (bus.burst_len == '0) begin
                            state  <= DONE;
                            done_r <= 1'b1;
                        end else begin
                            state  <= RUN;
                            busy_r <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (rd_en) begin
                        issue_left <= issue_left - LEN_ONE;
                        if (issue_left == LEN_ONE) begin
                            state <= DRAIN;
                        end
                    end
                    if (hs) begin
                        deliver_left <= deliver_left - LEN_ONE;
                    end
                end
                DRAIN: begin
                    if (hs) begin
                        deliver_left <= deliver_left - LEN_ONE;
                        if (deliver_left == LEN_ONE) begin
                            state  <= DONE;
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef FIFO_READER_STATS_EN
    localparam logic [STAT_WIDTH-1:0] STAT_ONE = STAT_WIDTH'(1);

    logic [STAT_WIDTH-1:0] stat_words;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_words <= '0;
        end else if (hs) begin
            stat_words <= stat_words + STAT_ONE;
        end
    end

    assign bus.stat_words = stat_words;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader: a queue-based FIFO model feeds the DUT, a monitor checks the stream.
module tb_fifo_stream_reader;

    localparam int DW = 8;
    localparam int LW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_stream_reader_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

    fifo_stream_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] exp_q[$];
    int  fq_cnt       = 0;
    int  underflow    = 0;
    bit  hold_empty   = 1'b0;
    bit  rand_mode    = 1'b0;
    bit  ready_cmd    = 1'b1;
    bit  empty_cmd    = 1'b0;
    int  exp_done_cyc = -1;
    int  rd_cnt = 0, run = 0, max_run = 0;
    int  hs_run = 0, hs_max = 0, vld_cnt = 0, busy_low = 0;
    int  stat_exp = 0;
    bit  prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    bit  got_rd = 1'b0, got_v = 1'b0;
    int  rd_cyc = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Source FIFO model: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (rst) begin
            fq.delete();
        end else if (bus.fifo_rd_en) begin
            if (fq.size() > 0) bus.fifo_dout <= fq.pop_front();
            else               underflow++;
        end
        fq_cnt <= fq.size();
    end

    assign bus.fifo_empty = hold_empty || (fq_cnt == 0);

    always @(posedge clk) begin
        #2;
        if (rand_mode) begin
            bus.m_ready = ($urandom_range(0, 3) != 0);
            hold_empty  = ($urandom_range(0, 4) == 0);
        end else begin
            bus.m_ready = ready_cmd;
            hold_empty  = empty_cmd;
        end
    end

    // Monitor: pops the scoreboard on every handshake and checks protocol rules.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
            got_rd     = 1'b0;
            got_v      = 1'b0;
            stat_exp   = 0;
        end else begin
            check("rd_while_empty", 32'(bus.fifo_rd_en && bus.fifo_empty), 32'd0);
            if (bus.fifo_rd_en) begin
                rd_cnt++;
                run++;
                if (run > max_run) max_run = run;
                if (!got_rd) begin
                    got_rd = 1'b1;
                    rd_cyc = cyc;
                end
            end else begin
                run = 0;
            end
            if (bus.m_valid) vld_cnt++;
            if (prev_stall) begin
                check("stall_valid", 32'(bus.m_valid), 32'd1);
                check("stall_data", 32'(bus.m_data), 32'(prev_data));
            end
            if (bus.m_valid && !got_v) begin
                got_v = 1'b1;
                check("first_latency", 32'(cyc - rd_cyc), 32'd2);
            end
            if (bus.m_valid && bus.m_ready) begin
                hs_run++;
                if (hs_run > hs_max) hs_max = hs_run;
                stat_exp++;
                if (exp_q.size() == 0) begin
                    check("extra_word", 32'(bus.m_data), 32'hFFFF_FFFF);
                end else begin
                    check("data", 32'(bus.m_data), 32'(exp_q.pop_front()));
                    if (exp_q.size() == 0) exp_done_cyc = cyc + 1;
                end
            end else begin
                hs_run = 0;
            end
            if (bus.done) begin
                check("done_cycle", 32'(cyc), 32'(exp_done_cyc));
                check("busy_in_done", 32'(bus.busy), 32'd0);
                exp_done_cyc = -1;
                got_rd = 1'b0;
                got_v  = 1'b0;
            end else if (exp_done_cyc == cyc) begin
                check("done_missing", 32'(bus.done), 32'd1);
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
        end
    end

    task automatic tick();
        @(negedge clk);
        if (!bus.busy && !bus.done) busy_low++;
    endtask

    task automatic preload(input int n);
        for (int i = 0; i < n; i++) fq.push_back(DW'($urandom));
    endtask

    task automatic issue(input int len);
        @(posedge clk); #1;
        for (int i = 0; i < len; i++) exp_q.push_back(fq[i]);
        if (len == 0) exp_done_cyc = cyc + 1;
        rd_cnt = 0; max_run = 0; hs_max = 0; vld_cnt = 0; busy_low = 0;
        bus.start     = 1'b1;
        bus.burst_len = LW'(len);
        @(posedge clk); #1;
        bus.start     = 1'b0;
        bus.burst_len = LW'($urandom);
    endtask

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (bus.done) seen = 1'b1;
        end
        check("done_seen", 32'(seen), 32'd1);
        check("busy_held", 32'(busy_low), 32'd0);
`ifdef FIFO_READER_STATS_EN
        check("stat_words", 32'(bus.stat_words), 32'(stat_exp & 16'hFFFF));
`endif
    endtask

    task automatic rst_pulse();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        exp_done_cyc = -1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start     = 1'b0;
        bus.burst_len = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_m_valid", 32'(bus.m_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        check("rst_m_data", 32'(bus.m_data), 32'd0);

        // Four preloaded words at full rate, with a start pulse mid-burst that must be ignored.
        fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33); fq.push_back(8'h44);
        ready_cmd = 1'b1;
        issue(4);
        tick(); tick();
        bus.start = 1'b1; bus.burst_len = 8'd9;
        tick();
        bus.start = 1'b0;
        wait_done(40);
        check("t1_rd_cnt", 32'(rd_cnt), 32'd4);
        check("t1_rd_run", 32'(max_run), 32'd4);
        check("t1_hs_run", 32'(hs_max), 32'd4);

        // Stalled sink: only two reads issue, head word held until ready rises.
        fq.push_back(8'hA1); fq.push_back(8'hB2); fq.push_back(8'hC3);
        ready_cmd = 1'b0;
        issue(3);
        repeat (10) tick();
        check("t2_rd_cnt", 32'(rd_cnt), 32'd2);
        check("t2_m_valid", 32'(bus.m_valid), 32'd1);
        check("t2_m_data", 32'(bus.m_data), 32'hA1);
        ready_cmd = 1'b1;
        wait_done(40);
        check("t2_rd_total", 32'(rd_cnt), 32'd3);

        // FIFO runs dry for five cycles after the second read of a six-word burst.
        preload(6);
        issue(6);
        for (int i = 0; i < 40 && rd_cnt < 2; i++) tick();
        check("t3_rd_two", 32'(rd_cnt), 32'd2);
        empty_cmd = 1'b1;
        repeat (5) tick();
        empty_cmd = 1'b0;
        wait_done(60);
        check("t3_rd_cnt", 32'(rd_cnt), 32'd6);

        // Zero-length burst.
        issue(0);
        wait_done(5);
        check("t4_rd_cnt", 32'(rd_cnt), 32'd0);
        check("t4_vld_cnt", 32'(vld_cnt), 32'd0);

        // Reset with two words buffered.
        preload(5);
        ready_cmd = 1'b0;
        issue(5);
        repeat (8) tick();
        check("t5_pre_valid", 32'(bus.m_valid), 32'd1);
        rst_pulse();
        @(negedge clk);
        check("t5_m_valid", 32'(bus.m_valid), 32'd0);
        check("t5_busy", 32'(bus.busy), 32'd0);
        check("t5_done", 32'(bus.done), 32'd0);
        check("t5_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        check("t5_m_data", 32'(bus.m_data), 32'd0);
`ifdef FIFO_READER_STATS_EN
        check("t5_stat_clr", 32'(bus.stat_words), 32'd0);
`endif
        ready_cmd = 1'b1;
        preload(2);
        issue(2);
        wait_done(30);

        // Random bursts with random backpressure and FIFO gaps.
        rand_mode = 1'b1;
        for (int b = 0; b < 20; b++) begin
            int len;
            int extra;
            len   = $urandom_range(1, 24);
            extra = $urandom_range(0, 3);
            while (fq.size() < len + extra) fq.push_back(DW'($urandom));
            issue(len);
            wait_done(len * 12 + 60);
        end
        rand_mode = 1'b0;
        ready_cmd = 1'b1;
        empty_cmd = 1'b0;

        // Three 100-word bursts from a fresh reset.
        rst_pulse();
        for (int b = 0; b < 3; b++) begin
            preload(100);
            issue(100);
            wait_done(400);
        end
`ifdef FIFO_READER_STATS_EN
        check("t7_stat_300", 32'(bus.stat_words), 32'd300);
        rst_pulse();
        @(negedge clk);
        check("t7_stat_rst", 32'(bus.stat_words), 32'd0);
`endif

        check("fifo_underflow", 32'(underflow), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of FIFO and stream data.
REQ-002 SHALL have parameter LEN_WIDTH, default 8, width of burst_len and internal word counters.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  burst request; sampled only in IDLE.
REQ-006 SHALL have port burst_len  input  LEN_WIDTH  words to transfer; sampled with start.
REQ-007 SHALL have port busy  output  1  high in RUN and DRAIN.
REQ-008 SHALL have port done  output  1  one-cycle pulse at burst completion.
REQ-009 SHALL have port fifo_rd_en  output  1  read strobe to the FIFO read side.
REQ-010 SHALL have port fifo_dout  input  DATA_WIDTH  FIFO read data, valid the cycle after fifo_rd_en.
REQ-011 SHALL have port fifo_empty  input  1  FIFO empty flag.
REQ-012 SHALL have ports m_valid (output, 1), m_ready (input, 1) and m_data (output, DATA_WIDTH) forming the downstream valid/ready stream.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DRAIN and DONE.
REQ-014 IDLE: start=1 SHALL load issue_left and deliver_left from burst_len, then go to DONE if burst_len==0, else to RUN.
REQ-015 start SHALL be ignored in RUN, DRAIN and DONE; burst_len SHALL be ignored except in the start cycle.
REQ-016 RUN: fifo_rd_en SHALL equal !fifo_empty && issue_left!=0 && (buf_count + pending - (m_valid&&m_ready)) <= 1; each assertion SHALL decrement issue_left.
REQ-017 RUN SHALL go to DRAIN on the edge where issue_left reaches 0; fifo_rd_en SHALL be 0 outside RUN and whenever fifo_empty=1.
REQ-018 pending SHALL be a register equal to the previous cycle's fifo_rd_en; when pending=1, fifo_dout SHALL be written into a 2-entry output buffer at the next edge.
REQ-019 m_valid SHALL be (buf_count!=0) and m_data SHALL be the buffer head; m_data SHALL stay stable while m_valid && !m_ready.
REQ-020 A simultaneous buffer write and pop SHALL leave buf_count unchanged; the buffer SHALL never overflow.
REQ-021 Word order SHALL be preserved.
REQ-022 First m_valid SHALL occur 2 cycles after the first fifo_rd_en.
REQ-023 Sustained throughput SHALL be 1 word/cycle while the FIFO is non-empty and m_ready=1.
REQ-024 Each m_valid&&m_ready SHALL decrement deliver_left; DRAIN SHALL go to DONE on the edge where deliver_left reaches 0.
REQ-025 DONE SHALL assert done=1 for exactly one cycle, then go to IDLE; busy SHALL be 0 in DONE.

Reset
REQ-026 rst=1 SHALL at the next edge force state=IDLE, clear issue_left, deliver_left, pending and buf_count, and drive busy, done, fifo_rd_en and m_valid to 0.
REQ-027 m_data SHALL reset to 0.
REQ-028 Reset mid-burst SHALL discard buffered and in-flight words; the FIFO itself is not reset by this block.

Configuration
REQ-029 Macro FIFO_READER_STATS_EN defined: the block SHALL add output stat_words (16 bits), which increments on each m_valid&&m_ready, wraps from 0xFFFF to 0, and is cleared only by rst.
REQ-030 Macro FIFO_READER_STATS_EN undefined: the port and the counter SHALL be absent, with all other behaviour identical.

Structure
REQ-031 Package fifo_reader_pkg SHALL hold the state enum rd_state_e and the constants BUF_DEPTH=2 and STAT_WIDTH=16.
REQ-032 The 2-entry output buffer SHALL be sub-module fifo_reader_buf (write, pop, head, count).

Verification
REQ-033 FIFO preloaded with 0x11,0x22,0x33,0x44, burst_len=4, m_ready=1 -> fifo_rd_en high 4 consecutive cycles; m_data 0x11..0x44 on 4 consecutive cycles; done pulses once, the cycle after the last handshake.
REQ-034 burst_len=3, m_ready=0 -> exactly 2 fifo_rd_en pulses; m_valid=1 with m_data=first word, stable; raising m_ready delivers the remaining words in order, then done.
REQ-035 fifo_empty=1 for 5 cycles after word 2 of a 6-word burst -> no fifo_rd_en during empty; all 6 words delivered; busy held until done.
REQ-036 burst_len=0 -> done=1 in the cycle after start; no fifo_rd_en; no m_valid.
REQ-037 rst pulsed mid-burst with 2 words buffered -> next cycle m_valid=0, busy=0, state IDLE; start asserted during a burst is ignored.
REQ-038 FIFO_READER_STATS_EN defined, three 100-word bursts -> stat_words=300; after rst, stat_words=0.
